// File: rtl/dmem_ctrl.sv
// Data-side memory controller: byte-writable word RAM plus LED, switch and
// compare-timer registers, with read data returned one cycle after the access.
module dmem_ctrl #(
  parameter int unsigned RAM_AW  = 10,
  parameter logic [31:0] IO_BASE = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dce,
  input  logic [31:0] daddr,
  input  logic [3:0]  we,
  input  logic [31:0] din,
  output logic [31:0] dm,
  input  logic [15:0] sw,
  output logic [15:0] led,
  output logic        timer_irq
);

  typedef enum logic [1:0] {SRC_ZERO, SRC_RAM, SRC_IO} rd_src_t;
  typedef enum logic [2:0] {REG_LED, REG_SW, REG_CNT, REG_CMP, REG_CTRL, REG_NONE} io_reg_t;

  logic [31:0]       ram [2**RAM_AW];
  logic [31:0]       ram_q;
  logic [31:0]       io_q;
  rd_src_t           src_q;

  logic [31:0]       cnt;
  logic [31:0]       cmp;
  logic              en;
  logic              pend;
  logic [15:0]       sw_s1;
  logic [15:0]       sw_s2;

  logic              is_ram;
  logic              is_io;
  logic              rd_en;
  logic              wr_en;
  logic              match;
  logic              pend_clr;
  io_reg_t           io_sel;
  logic [RAM_AW-1:0] ram_idx;
  logic [31:0]       wmask;
  logic [31:0]       io_rdata;
  logic [15:0]       led_w;
  logic [31:0]       cnt_w;
  logic [31:0]       cmp_w;
  logic              unused_ok;

  always_comb begin
    is_ram    = daddr[31:RAM_AW+2] == '0;
    is_io     = daddr[31:16] == IO_BASE[31:16];
    rd_en     = dce && (we == '0);
    wr_en     = dce && (we != '0);
    ram_idx   = daddr[RAM_AW+1:2];
    unused_ok = ^daddr[1:0];
    match     = cnt == cmp;

    for (int unsigned i = 0; i < 4; i++) begin
      wmask[8*i +: 8] = {8{we[i]}};
    end

    case (daddr[15:2])
      14'd0:   io_sel = REG_LED;
      14'd1:   io_sel = REG_SW;
      14'd2:   io_sel = REG_CNT;
      14'd3:   io_sel = REG_CMP;
      14'd4:   io_sel = REG_CTRL;
      default: io_sel = REG_NONE;
    endcase

    case (io_sel)
      REG_LED:  io_rdata = {16'h0000, led};
      REG_SW:   io_rdata = {16'h0000, sw_s2};
      REG_CNT:  io_rdata = cnt;
      REG_CMP:  io_rdata = cmp;
      REG_CTRL: io_rdata = {30'd0, pend, en};
      default:  io_rdata = '0;
    endcase

    led_w    = (led & ~wmask[15:0]) | (din[15:0] & wmask[15:0]);
    cnt_w    = (cnt & ~wmask) | (din & wmask);
    cmp_w    = (cmp & ~wmask) | (din & wmask);
    pend_clr = wr_en && is_io && !is_ram && (io_sel == REG_CTRL) && we[0] && din[1];
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_en && is_ram) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (we[i]) begin
          ram[ram_idx][8*i +: 8] <= din[8*i +: 8];
        end
      end
    end
    if (rd_en && is_ram) begin
      ram_q <= ram[ram_idx];
    end
  end

  // dm is a mux of registered sources only, so it changes solely at a read edge
  always_ff @(posedge clk) begin
    if (rst) begin
      src_q <= SRC_ZERO;
      io_q  <= '0;
    end else if (rd_en) begin
      if (is_ram) begin
        src_q <= SRC_RAM;
      end else if (is_io) begin
        src_q <= SRC_IO;
        io_q  <= io_rdata;
      end else begin
        src_q <= SRC_ZERO;
      end
    end
  end

  always_comb begin
    case (src_q)
      SRC_RAM: dm = ram_q;
      SRC_IO:  dm = io_q;
      default: dm = '0;
    endcase
  end

  // software writes are placed last so they override the timer update
  always_ff @(posedge clk) begin
    if (rst) begin
      led   <= '0;
      cnt   <= '0;
      cmp   <= '1;
      en    <= 1'b0;
      pend  <= 1'b0;
      sw_s1 <= '0;
      sw_s2 <= '0;
    end else begin
      sw_s1 <= sw;
      sw_s2 <= sw_s1;
      if (en) begin
        if (match) begin
          cnt  <= '0;
          pend <= 1'b1;
        end else begin
          cnt <= cnt + 32'd1;
        end
      end
      if (pend_clr && !(en && match)) begin
        pend <= 1'b0;
      end
      if (wr_en && is_io && !is_ram) begin
        case (io_sel)
          REG_LED:  led <= led_w;
          REG_CNT:  cnt <= cnt_w;
          REG_CMP:  cmp <= cmp_w;
          REG_CTRL: if (we[0]) en <= din[0];
          default:  ;
        endcase
      end
    end
  end

  assign timer_irq = pend;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl with a cycle-level behavioural model of the
// memory map and timer; outputs are compared after every clock edge.
`timescale 1ns/1ps
module tb_dmem_ctrl;

  localparam logic [31:0] A_LED  = 32'hFFFF_0000;
  localparam logic [31:0] A_SW   = 32'hFFFF_0004;
  localparam logic [31:0] A_CNT  = 32'hFFFF_0008;
  localparam logic [31:0] A_CMP  = 32'hFFFF_000C;
  localparam logic [31:0] A_CTRL = 32'hFFFF_0010;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dce = 1'b0;
  logic [31:0] daddr = '0;
  logic [3:0]  we = '0;
  logic [31:0] din = '0;
  logic [31:0] dm;
  logic [15:0] sw = '0;
  logic [15:0] led;
  logic        timer_irq;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] m_ram [1024];
  logic [31:0] m_dm = '0, m_cnt = '0, m_cmp = '1;
  logic [15:0] m_led = '0, m_s1 = '0, m_s2 = '0;
  logic        m_en = 1'b0, m_pend = 1'b0;

  dmem_ctrl #(.RAM_AW(10), .IO_BASE(32'hFFFF_0000)) dut (
    .clk(clk), .rst(rst), .dce(dce), .daddr(daddr), .we(we), .din(din),
    .dm(dm), .sw(sw), .led(led), .timer_irq(timer_irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (a < 32'h0000_1000) return m_ram[a[11:2]];
    if (a[31:16] != 16'hFFFF) return 32'h0;
    case (a[15:0] & 16'hFFFC)
      16'h0000: return {16'h0, m_led};
      16'h0004: return {16'h0, m_s2};
      16'h0008: return m_cnt;
      16'h000C: return m_cmp;
      16'h0010: return {30'h0, m_pend, m_en};
      default:  return 32'h0;
    endcase
  endfunction

  // One clock: drive inputs, predict the post-edge state, then compare.
  task automatic step(input logic c, input logic [31:0] a, input logic [3:0] w,
                      input logic [31:0] d, input logic r);
    logic [31:0] mask, merged, n_dm, n_cnt, n_cmp_r;
    logic [15:0] n_led, n_s1, n_s2;
    logic        n_en, n_pend, hit;
    dce = c; daddr = a; we = w; din = d; rst = r;
    mask = {{8{w[3]}}, {8{w[2]}}, {8{w[1]}}, {8{w[0]}}};
    n_dm = m_dm; n_cnt = m_cnt; n_cmp_r = m_cmp; n_led = m_led;
    n_en = m_en; n_pend = m_pend; n_s1 = sw; n_s2 = m_s1;
    hit = m_en && (m_cnt == m_cmp);
    if (r) begin
      n_dm = 0; n_cnt = 0; n_cmp_r = 32'hFFFF_FFFF; n_led = 0;
      n_en = 0; n_pend = 0; n_s1 = 0; n_s2 = 0;
    end else begin
      if (m_en) begin
        if (hit) begin n_cnt = 0; n_pend = 1; end
        else n_cnt = m_cnt + 1;
      end
      if (c && w == 4'h0) n_dm = model_read(a);
      if (c && w != 4'h0) begin
        if (a < 32'h0000_1000) begin
          m_ram[a[11:2]] = (m_ram[a[11:2]] & ~mask) | (d & mask);
        end else if (a[31:16] == 16'hFFFF) begin
          case (a[15:0] & 16'hFFFC)
            16'h0000: begin merged = ({16'h0, m_led} & ~mask) | (d & mask); n_led = merged[15:0]; end
            16'h0008: n_cnt = (m_cnt & ~mask) | (d & mask);
            16'h000C: n_cmp_r = (m_cmp & ~mask) | (d & mask);
            16'h0010: if (w[0]) begin
                        n_en = d[0];
                        if (d[1] && !hit) n_pend = 0;
                      end
            default: ;
          endcase
        end
      end
    end
    @(posedge clk);
    #1;
    m_dm = n_dm; m_cnt = n_cnt; m_cmp = n_cmp_r; m_led = n_led;
    m_en = n_en; m_pend = n_pend; m_s1 = n_s1; m_s2 = n_s2;
    chk("dm", dm, m_dm);
    chk("led", {16'h0, led}, {16'h0, m_led});
    chk("irq", {31'h0, timer_irq}, {31'h0, m_pend});
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
    step(1'b1, a, w, d, 1'b0);
  endtask

  task automatic rd(input logic [31:0] a);
    step(1'b1, a, 4'h0, 32'h0, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) m_ram[i] = '0;

    step(1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
    chk("reset_dm", dm, 32'h0);
    chk("reset_led", {16'h0, led}, 32'h0);
    chk("reset_irq", {31'h0, timer_irq}, 32'h0);

    wr(32'h0000_0010, 32'h1122_3344, 4'hF);
    wr(32'h0000_0010, 32'hAABB_CCDD, 4'b0101);
    rd(32'h0000_0010);
    chk("ram_lanes", dm, 32'h11BB_33DD);

    rd(32'h0001_0000);
    chk("unmapped_rd", dm, 32'h0);

    wr(32'h0000_0000, 32'hCAFE_F00D, 4'hF);
    wr(32'h0000_0FFC, 32'h0BAD_BEEF, 4'hF);
    wr(32'h0000_1000, 32'hDEAD_DEAD, 4'hF);
    rd(32'h0000_0000);
    chk("ram_no_alias", dm, 32'hCAFE_F00D);
    rd(32'h0000_0FFC);
    chk("ram_last_word", dm, 32'h0BAD_BEEF);

    wr(A_LED, 32'h1234_5678, 4'hF);
    chk("led_write", {16'h0, led}, 32'h0000_5678);
    rd(A_LED);
    chk("led_read", dm, 32'h0000_5678);
    wr(A_LED, 32'h0000_AB00, 4'b0010);
    chk("led_partial", {16'h0, led}, 32'h0000_AB78);
    wr(32'hFFFF_0020, 32'hFFFF_FFFF, 4'hF);
    rd(32'hFFFF_0020);
    chk("io_hole", dm, 32'h0);

    sw = 16'hA5A5;
    idle();
    idle();
    rd(A_SW);
    chk("sw_sync", dm, 32'h0000_A5A5);

    wr(A_CMP, 32'd5, 4'hF);
    wr(A_CNT, 32'd0, 4'hF);
    wr(A_CTRL, 32'd1, 4'hF);
    for (int k = 0; k < 7; k++) begin
      rd(A_CNT);
      chk("cnt_seq", dm, (k == 6) ? 32'd0 : 32'(k));
      chk("irq_seq", {31'h0, timer_irq}, (k >= 5) ? 32'd1 : 32'd0);
    end
    wr(A_CTRL, 32'h3, 4'h1);
    chk("irq_cleared", {31'h0, timer_irq}, 32'd0);

    idle();
    idle();
    idle();
    wr(A_CTRL, 32'h3, 4'h1);
    chk("clear_vs_match", {31'h0, timer_irq}, 32'd1);
    wr(A_CTRL, 32'h3, 4'h1);
    chk("irq_cleared2", {31'h0, timer_irq}, 32'd0);

    wr(A_CNT, 32'd100, 4'hF);
    rd(A_CNT);
    chk("cnt_write_wins", dm, 32'd100);

    wr(A_LED, 32'h0000_FFFF, 4'hF);
    wr(32'h0000_0020, 32'h55AA_55AA, 4'hF);
    rd(32'h0000_0020);
    chk("pre_reset_rd", dm, 32'h55AA_55AA);
    step(1'b1, 32'h0000_0020, 4'hF, 32'h1234_5678, 1'b1);
    chk("rst_led", {16'h0, led}, 32'h0);
    chk("rst_dm", dm, 32'h0);
    rd(A_CNT);
    chk("rst_cnt", dm, 32'h0);
    rd(A_CMP);
    chk("rst_cmp", dm, 32'hFFFF_FFFF);
    rd(A_CTRL);
    chk("rst_ctrl", dm, 32'h0);
    rd(32'h0000_0020);
    chk("rst_ram_kept", dm, 32'h55AA_55AA);

    rd(32'h0000_0010);
    for (int k = 0; k < 3; k++) begin
      idle();
      chk("hold_idle", dm, 32'h11BB_33DD);
    end
    wr(32'h0000_0010, 32'h0, 4'hF);
    chk("hold_write", dm, 32'h11BB_33DD);
    rd(32'h0000_0010);
    chk("after_hold", dm, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
